// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: instruction field positions, opcodes,
// sequencer state encoding and the illegal-opcode classifier.
package cpu_pkg;

    localparam int INSTR_W = 19;
    localparam int OPC_MSB = 18;
    localparam int OPC_LSB = 14;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_NOT   = 5'b00101;
    localparam logic [4:0] OP_SHL   = 5'b00110;
    localparam logic [4:0] OP_SHR   = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_MOV   = 5'b01001;
    localparam logic [4:0] OP_LOAD  = 5'b01010;
    localparam logic [4:0] OP_STORE = 5'b01011;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_e;

    // Unassigned opcode space sits between STORE and HALT.
    function automatic logic is_illegal(input logic [4:0] opc);
        return (opc >= 5'b01100) && (opc <= 5'b11110);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; o_expire flags the last permitted
// wait cycle so the sequencer can fault instead of waiting again.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expire
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] r_count;

    // Expires while the MEM_TIMEOUT-th wait cycle is still unanswered.
    assign o_expire = i_count && (r_count == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: owns the IR, steps FETCH/DECODE/EXEC/MEM/WB,
// and handles HALT, illegal opcodes, memory-wait timeout and retired counting.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int         MEM_TIMEOUT = 16,
    parameter int         CNT_W       = 16,
    parameter logic [4:0] HALT_OP     = OP_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               mem_ready,
    input  logic               dec_mem_read,
    input  logic               dec_mem_write,
    input  logic               dec_reg_write,
    output logic [INSTR_W-1:0] ir_out,
    output logic               pc_en,
    output logic               ir_load,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               mdr_load,
    output logic               rf_we,
    output logic               halted,
    output logic               fault,
    output logic               illegal_seen,
    output logic [CNT_W-1:0]   retired,
    output logic [2:0]         state
);

    state_e             r_state;
    state_e             w_next;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_retired;
    logic               r_illegal_seen;
    logic [4:0]         w_opc;
    logic               w_illegal;
    logic               w_waiting;
    logic               w_expire;

    assign w_opc     = r_ir[OPC_MSB:OPC_LSB];
    assign w_illegal = is_illegal(w_opc) && (w_opc != HALT_OP);
    assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

    // Timer stays cleared outside wait cycles, so every FETCH/MEM entry starts at zero.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!w_waiting),
        .i_count (w_waiting),
        .o_expire(w_expire)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
                      else if (w_expire) w_next = S_FAULT;
            S_DECODE: if (w_opc == HALT_OP) w_next = S_HALT;
                      else if (w_illegal) w_next = S_WB;
                      else if (dec_mem_read && dec_mem_write) w_next = S_FAULT;
                      else w_next = S_EXEC;
            S_EXEC:   w_next = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
            S_MEM:    if (mem_ready) w_next = S_WB;
                      else if (w_expire) w_next = S_FAULT;
            S_WB:     w_next = run ? S_FETCH : S_IDLE;
            S_HALT:   w_next = S_HALT;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_retired      <= '0;
            r_illegal_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_FETCH) && mem_ready) r_ir <= instr_in;
            if ((r_state == S_DECODE) && w_illegal) r_illegal_seen <= 1'b1;
            if (r_state == S_WB) r_retired <= r_retired + 1'b1;
        end
    end

    // Strobes are held low while rst is high so nothing commits on the reset edge.
    assign mem_req  = !rst && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we   = !rst && (r_state == S_MEM) && dec_mem_write;
    assign addr_sel = !rst && (r_state == S_MEM);
    assign ir_load  = !rst && (r_state == S_FETCH) && mem_ready;
    assign mdr_load = !rst && (r_state == S_MEM) && mem_ready && !dec_mem_write;
    assign pc_en    = !rst && (r_state == S_WB);
    assign rf_we    = !rst && (r_state == S_WB) && dec_reg_write && !w_illegal;
    assign halted   = (r_state == S_HALT);
    assign fault    = (r_state == S_FAULT);

    assign ir_out       = r_ir;
    assign illegal_seen = r_illegal_seen;
    assign retired      = r_retired;
    assign state        = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small behavioural opcode decoder.
module tb_cpu_sequencer;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
    localparam logic [2:0] MEM = 3'd4, WB = 3'd5, HALT = 3'd6, FAULT = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [18:0] instr_in = '0;
    logic        mem_ready = 1'b1;
    logic        force_both = 1'b0;
    logic        dec_mem_read, dec_mem_write, dec_reg_write;
    logic [18:0] ir_out;
    logic        pc_en, ir_load, mem_req, mem_we, addr_sel, mdr_load, rf_we;
    logic        halted, fault, illegal_seen;
    logic [3:0]  retired;
    logic [2:0]  state;
    logic [4:0]  opc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Decoder asserts reg_write for everything but STORE, including illegal opcodes.
    assign opc           = ir_out[18:14];
    assign dec_mem_read  = force_both | (opc == 5'b01010);
    assign dec_mem_write = force_both | (opc == 5'b01011);
    assign dec_reg_write = (opc != 5'b01011);

    cpu_sequencer #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .mem_ready(mem_ready),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .ir_out(ir_out), .pc_en(pc_en),
        .ir_load(ir_load), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .mdr_load(mdr_load), .rf_we(rf_we), .halted(halted), .fault(fault),
        .illegal_seen(illegal_seen), .retired(retired), .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b1; force_both = 1'b0; instr_in = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (ir_out !== 19'd0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir_out); end
        checks++; if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if ({pc_en, ir_load, mem_req, mem_we, addr_sel, mdr_load, rf_we, halted, fault, illegal_seen} !== 10'd0)
            begin failures++; $display("FAIL reset_strobes got=%b exp=0", {pc_en, ir_load, mem_req, mem_we, addr_sel, mdr_load, rf_we, halted, fault, illegal_seen}); end
        tick();
        checks++; if (state !== IDLE) begin failures++; $display("FAIL idle_hold got=%0d exp=%0d", state, IDLE); end
    endtask

    task automatic test_alu();
        do_reset();
        instr_in = {5'b00000, 14'h0123}; run = 1'b1;
        tick();
        checks++; if (state !== FETCH || mem_req !== 1'b1 || ir_load !== 1'b1 || addr_sel !== 1'b0 || mem_we !== 1'b0)
            begin failures++; $display("FAIL alu_fetch state=%0d req=%b ld=%b sel=%b we=%b exp 1/1/1/0/0", state, mem_req, ir_load, addr_sel, mem_we); end
        tick();
        checks++; if (state !== DECODE || ir_out !== 19'h00123) begin failures++; $display("FAIL alu_decode state=%0d ir=%h exp 2/00123", state, ir_out); end
        tick();
        checks++; if (state !== EXEC || mem_req !== 1'b0) begin failures++; $display("FAIL alu_exec state=%0d req=%b exp 3/0", state, mem_req); end
        tick();
        checks++; if (state !== WB || pc_en !== 1'b1 || rf_we !== 1'b1 || retired !== 4'd0)
            begin failures++; $display("FAIL alu_wb state=%0d pc=%b rf=%b ret=%0d exp 5/1/1/0", state, pc_en, rf_we, retired); end
        run = 1'b0;
        tick();
        checks++; if (state !== IDLE || retired !== 4'd1 || pc_en !== 1'b0) begin failures++; $display("FAIL alu_retire state=%0d ret=%0d pc=%b exp 0/1/0", state, retired, pc_en); end
    endtask

    task automatic test_load_store();
        do_reset();
        instr_in = {5'b01010, 14'h0001}; run = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (state !== MEM || mem_req !== 1'b1 || mem_we !== 1'b0 || addr_sel !== 1'b1 || mdr_load !== 1'b1)
            begin failures++; $display("FAIL load_mem state=%0d req=%b we=%b sel=%b mdr=%b exp 4/1/0/1/1", state, mem_req, mem_we, addr_sel, mdr_load); end
        instr_in = {5'b01011, 14'h0002};
        tick();
        checks++; if (state !== WB || rf_we !== 1'b1 || pc_en !== 1'b1) begin failures++; $display("FAIL load_wb state=%0d rf=%b pc=%b exp 5/1/1", state, rf_we, pc_en); end
        tick();
        checks++; if (state !== FETCH || retired !== 4'd1) begin failures++; $display("FAIL load_done state=%0d ret=%0d exp 1/1", state, retired); end
        tick(); tick(); tick();
        checks++; if (state !== MEM || mem_we !== 1'b1 || mdr_load !== 1'b0 || addr_sel !== 1'b1)
            begin failures++; $display("FAIL store_mem state=%0d we=%b mdr=%b sel=%b exp 4/1/0/1", state, mem_we, mdr_load, addr_sel); end
        run = 1'b0;
        tick();
        checks++; if (state !== WB || rf_we !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL store_wb state=%0d rf=%b pc=%b exp 5/0/1", state, rf_we, pc_en); end
        tick();
        checks++; if (state !== IDLE || retired !== 4'd2) begin failures++; $display("FAIL store_done state=%0d ret=%0d exp 0/2", state, retired); end
    endtask

    task automatic test_wait_states();
        do_reset();
        instr_in = {5'b00001, 14'h0000}; mem_ready = 1'b0; run = 1'b1;
        tick();
        repeat (15) tick();
        checks++; if (state !== FETCH || fault !== 1'b0 || ir_load !== 1'b0) begin failures++; $display("FAIL wait_c16 state=%0d fault=%b ld=%b exp 1/0/0", state, fault, ir_load); end
        mem_ready = 1'b1;
        #1;
        checks++; if (ir_load !== 1'b1) begin failures++; $display("FAIL wait_irload got=%b exp=1", ir_load); end
        tick();
        checks++; if (state !== DECODE || fault !== 1'b0) begin failures++; $display("FAIL wait_decode state=%0d fault=%b exp 2/0", state, fault); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        instr_in = {5'b01010, 14'h0000}; mem_ready = 1'b0; run = 1'b1;
        tick();
        repeat (9) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick(); tick();
        checks++; if (state !== MEM || mdr_load !== 1'b0) begin failures++; $display("FAIL memwait_enter state=%0d mdr=%b exp 4/0", state, mdr_load); end
        repeat (15) tick();
        checks++; if (state !== MEM || fault !== 1'b0) begin failures++; $display("FAIL memwait_c16 state=%0d fault=%b exp 4/0", state, fault); end
        mem_ready = 1'b1; run = 1'b0;
        #1;
        checks++; if (mdr_load !== 1'b1) begin failures++; $display("FAIL memwait_mdr got=%b exp=1", mdr_load); end
        tick();
        checks++; if (state !== WB || fault !== 1'b0) begin failures++; $display("FAIL memwait_wb state=%0d fault=%b exp 5/0", state, fault); end
    endtask

    task automatic test_timeout();
        do_reset();
        instr_in = {5'b00000, 14'h0000}; mem_ready = 1'b0; run = 1'b1;
        tick();
        repeat (15) tick();
        checks++; if (state !== FETCH || fault !== 1'b0) begin failures++; $display("FAIL timeout_c16 state=%0d fault=%b exp 1/0", state, fault); end
        tick();
        checks++; if (state !== FAULT || fault !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL timeout_c17 state=%0d fault=%b req=%b exp 7/1/0", state, fault, mem_req); end
        mem_ready = 1'b1;
        tick(); tick();
        checks++; if (fault !== 1'b1 || state !== FAULT) begin failures++; $display("FAIL timeout_sticky state=%0d fault=%b exp 7/1", state, fault); end
        do_reset();
        checks++; if (fault !== 1'b0 || state !== IDLE) begin failures++; $display("FAIL timeout_clear state=%0d fault=%b exp 0/0", state, fault); end
    endtask

    task automatic test_halt();
        int pc_pulses;
        do_reset();
        pc_pulses = 0;
        instr_in = {5'b11111, 14'h0000}; run = 1'b1;
        tick(); tick(); tick();
        checks++; if (state !== HALT || halted !== 1'b1 || illegal_seen !== 1'b0) begin failures++; $display("FAIL halt_enter state=%0d halted=%b ill=%b exp 6/1/0", state, halted, illegal_seen); end
        repeat (5) begin
            if (pc_en === 1'b1) pc_pulses++;
            tick();
        end
        checks++; if (pc_pulses !== 0 || state !== HALT || retired !== 4'd0) begin failures++; $display("FAIL halt_hold pc=%0d state=%0d ret=%0d exp 0/6/0", pc_pulses, state, retired); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== IDLE || halted !== 1'b0) begin failures++; $display("FAIL halt_reset state=%0d halted=%b exp 0/0", state, halted); end
    endtask

    task automatic test_illegal();
        do_reset();
        instr_in = {5'b01100, 14'h0000}; run = 1'b1;
        tick(); tick();
        instr_in = {5'b00000, 14'h0000};
        tick();
        checks++; if (state !== WB || illegal_seen !== 1'b1 || rf_we !== 1'b0 || pc_en !== 1'b1)
            begin failures++; $display("FAIL illegal_wb state=%0d ill=%b rf=%b pc=%b exp 5/1/0/1", state, illegal_seen, rf_we, pc_en); end
        tick();
        checks++; if (state !== FETCH || retired !== 4'd1) begin failures++; $display("FAIL illegal_next state=%0d ret=%0d exp 1/1", state, retired); end
        tick(); tick(); tick();
        checks++; if (state !== WB || rf_we !== 1'b1 || illegal_seen !== 1'b1) begin failures++; $display("FAIL illegal_after state=%0d rf=%b ill=%b exp 5/1/1", state, rf_we, illegal_seen); end
        do_reset();
        instr_in = {5'b11110, 14'h0000}; run = 1'b1;
        tick(); tick(); tick();
        checks++; if (state !== WB || illegal_seen !== 1'b1) begin failures++; $display("FAIL illegal_top state=%0d ill=%b exp 5/1", state, illegal_seen); end
    endtask

    task automatic test_decode_fault();
        do_reset();
        instr_in = {5'b00000, 14'h0000}; run = 1'b1; force_both = 1'b1;
        tick(); tick(); tick();
        checks++; if (state !== FAULT || fault !== 1'b1) begin failures++; $display("FAIL dec_fault state=%0d fault=%b exp 7/1", state, fault); end
        force_both = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        instr_in = {5'b01011, 14'h0000}; run = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (state !== MEM || mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL midmem_wait state=%0d req=%b we=%b exp 4/1/1", state, mem_req, mem_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        checks++; if (state !== IDLE || mem_req !== 1'b0 || retired !== 4'd0) begin failures++; $display("FAIL midmem_reset state=%0d req=%b ret=%0d exp 0/0/0", state, mem_req, retired); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_in = {5'b00000, 14'h0000}; run = 1'b1;
        tick();
        repeat (60) tick();
        checks++; if (retired !== 4'd15 || state !== FETCH) begin failures++; $display("FAIL wrap_15 ret=%0d state=%0d exp 15/1", retired, state); end
        repeat (4) tick();
        checks++; if (retired !== 4'd0 || state !== FETCH) begin failures++; $display("FAIL wrap_0 ret=%0d state=%0d exp 0/1", retired, state); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_wait_states();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_illegal();
        test_decode_fault();
        test_reset_mid_mem();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer FSM for the 19-bit CPU.
- Owns the instruction register and drives the per-phase enables: PC advance, IR load, memory request, MDR load and register-file write.
- Sits between unified instruction/data memory, the opcode decoder (supplies dec_* flags from ir_out[18:14]) and the datapath.
- Adds a memory-wait timeout, HALT handling, illegal-opcode detection and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles per memory access before FAULT (>=1)
CNT_W, 16, width of retired-instruction counter
HALT_OP, 5'b11111, opcode that halts the core

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
run  input  1  level; start/continue execution
instr_in  input  19  memory read data, captured into IR during FETCH
mem_ready  input  1  memory handshake; access completes in the cycle it is high while mem_req=1
dec_mem_read  input  1  decoder flag for the current IR
dec_mem_write  input  1  decoder flag for the current IR
dec_reg_write  input  1  decoder flag for the current IR
ir_out  output  19  instruction register; opcode = ir_out[18:14]
pc_en  output  1  PC increments at this clock edge
ir_load  output  1  IR capture strobe
mem_req  output  1  memory access request
mem_we  output  1  write qualifier for mem_req
addr_sel  output  1  0 = PC, 1 = ALU result
mdr_load  output  1  datapath captures load data
rf_we  output  1  register-file write enable
halted  output  1  in HALT state
fault  output  1  in FAULT state
illegal_seen  output  1  sticky; an illegal opcode was decoded
retired  output  CNT_W  instructions completed, wraps modulo 2^CNT_W
state  output  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE; ir_out=0, retired=0, illegal_seen=0, wait timer=0.
  - All strobes (pc_en, ir_load, mem_req, mem_we, addr_sel, mdr_load, rf_we), halted and fault are 0.
  - rst mid-access aborts it. mem_req is low from the first cycle after the reset edge. No write or counter update occurs on the reset edge.
- Output timing:
  - Outputs decode from state (Moore).
  - Exceptions (Mealy): ir_load = FETCH & mem_ready; mdr_load = MEM & mem_ready & ~mem_we; rf_we = WB & dec_reg_write & ~illegal.
- illegal is defined as opcode in 5'b01100..5'b11110.
- States:
  - IDLE: nothing asserted. run=1 -> FETCH.
  - FETCH: mem_req=1, mem_we=0, addr_sel=0.
    - mem_ready -> IR <= instr_in, go to DECODE.
    - Otherwise timer++.
  - DECODE: one cycle; decoder flags settle.
    - opcode==HALT_OP -> HALT.
    - illegal -> illegal_seen<=1, go to WB as a NOP.
    - dec_mem_read & dec_mem_write both 1 -> FAULT.
    - Otherwise -> EXEC.
  - EXEC: one ALU cycle.
    - (dec_mem_read | dec_mem_write) -> MEM.
    - Otherwise -> WB.
  - MEM: mem_req=1, mem_we=dec_mem_write, addr_sel=1. Waits on mem_ready with the same timeout rule; mem_ready -> WB.
  - WB: pc_en=1, rf_we as above, retired++.
    - run=1 -> FETCH.
    - run=0 -> IDLE.
  - HALT: halted=1; no PC advance; run ignored; exit only via rst.
  - FAULT: fault=1; exit only via rst.
- Timeout rule:
  - The timer clears on entry to FETCH and to MEM.
  - mem_ready is accepted in wait cycles 1..MEM_TIMEOUT.
  - If the MEM_TIMEOUT-th consecutive cycle ends without mem_ready, next state is FAULT.
- Latency with zero-wait memory:
  - ALU instruction: 4 cycles, FETCH-DECODE-EXEC-WB.
  - Load or store: 5 cycles.
  - IDLE to first FETCH: 1 cycle.
- run deasserted mid-instruction: the instruction completes, then the FSM parks in IDLE after WB.
- retired wraps from 2^CNT_W-1 to 0. Illegal NOPs count as retired; HALT does not.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W=19, OPC_MSB=18, OPC_LSB=14.
  - Opcode constants: ADD..LOAD/STORE (5'b00000..5'b01011) and HALT.
  - State enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- One natural sub-module, mem_wait_timer: clear, count and expire outputs, parameterised by MEM_TIMEOUT.

Test Plan:
- ALU op: rst, run=1, mem_ready always 1, instr_in opcode 00000 -> state sequence FETCH, DECODE, EXEC, WB. rf_we=1 and pc_en=1 in WB. retired=1 after 5 cycles from run.
- Load then store:
  - LOAD (01010): MEM with mem_we=0, addr_sel=1, mdr_load=1, rf_we=1 in WB.
  - STORE (01011): MEM with mem_we=1, mdr_load=0, rf_we=0.
  - Each takes 5 cycles.
- Wait states: MEM_TIMEOUT=16, mem_ready low in FETCH for 15 cycles and high on cycle 16 -> DECODE, no fault. Repeat with mem_ready never high -> fault=1 on cycle 17 and stays 1 with mem_ready later high.
- HALT: opcode 11111 -> halted=1 after DECODE. pc_en never pulses. retired unchanged. rst clears to IDLE with halted=0.
- Illegal: opcode 01100 -> illegal_seen=1, WB with rf_we=0 and pc_en=1, retired increments, next FETCH proceeds.
- Reset mid-MEM: assert rst during a store wait -> next cycle mem_req=0, state=IDLE, retired unchanged. With CNT_W=4, retiring 16 instructions -> retired=0.
